encoder_k3_viterbi_decoder: RTL

ENCODER_K3_VITERBI_DECODER -- requirements
Module: encoder_k3_viterbi_decoder

---
 rtl/encoder_k3_viterbi_decoder.sv | 82 ++++++++
 1 files changed

// File: rtl/encoder_k3_viterbi_decoder.sv
// encoder_k3_viterbi_decoder: hard-decision register-exchange Viterbi decoder for the K=3 (7,5) code
// Ports: clk, rst (sync, active-high); in_valid/encoded_pair/frame_start carry one received symbol;
//        decoded_bit/decoded_valid emit one decoded bit per accepted symbol once TB_DEPTH-1 symbols are in.
module encoder_k3_viterbi_decoder #(
  parameter int TB_DEPTH = 16,
  parameter int PM_W = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [1:0] encoded_pair,
  input  logic       frame_start,
  output logic       decoded_bit,
  output logic       decoded_valid
);
  localparam int CW = $clog2(TB_DEPTH);
  localparam logic [CW-1:0] CMAX = CW'(TB_DEPTH - 1);
  logic [PM_W-1:0] pm_q [4];
  logic [PM_W-1:0] pm_b [4];
  logic [PM_W-1:0] pm_d [4];
  logic [TB_DEPTH-1:0] surv_q [4];
  logic [TB_DEPTH-1:0] surv_b [4];
  logic [TB_DEPTH-1:0] surv_d [4];
  logic [PM_W:0] cand [4];
  logic [PM_W:0] mn;
  logic [1:0] best;
  logic [CW-1:0] cnt_q, cnt_b, cnt_d;
  logic valid_d, bit_d;
  function automatic logic [1:0] bm(input logic [1:0] p, input logic u, input logic [1:0] r);
    logic [1:0] d;
    d = {u ^ p[1] ^ p[0], u ^ p[0]} ^ r;
    return {1'b0, d[1]} + {1'b0, d[0]};
  endfunction
  // Per next state {u,a}: predecessors {a,0} and {a,1}; _b values are the frame_start-reloaded view.
  for (genvar g = 0; g < 4; g++) begin : g_acs
    localparam logic U = (g >= 2);
    localparam logic [1:0] P0 = 2'((g % 2) * 2);
    localparam logic [1:0] P1 = P0 | 2'd1;
    logic [PM_W:0] c0, c1;
    logic sel;
    assign pm_b[g] = frame_start ? (g == 0 ? '0 : PM_W'(8)) : pm_q[g];
    assign surv_b[g] = frame_start ? '0 : surv_q[g];
    assign c0 = {1'b0, pm_b[P0]} + (PM_W+1)'(bm(P0, U, encoded_pair));
    assign c1 = {1'b0, pm_b[P1]} + (PM_W+1)'(bm(P1, U, encoded_pair));
    assign sel = c1 < c0;
    assign cand[g] = sel ? c1 : c0;
    assign surv_d[g] = ((sel ? surv_b[P1] : surv_b[P0]) << 1) | TB_DEPTH'(U);
    assign pm_d[g] = PM_W'(cand[g] - mn);
  end
  always_comb begin
    mn = cand[0];
    best = 2'd0;
    for (int s = 1; s < 4; s++)
      if (cand[s] < mn) begin
        mn = cand[s];
        best = 2'(s);
      end
    cnt_b = frame_start ? '0 : cnt_q;
    cnt_d = (cnt_b == CMAX) ? cnt_b : cnt_b + 1'b1;
    valid_d = cnt_b == CMAX;
    bit_d = valid_d ? surv_d[best][TB_DEPTH-1] : decoded_bit;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 4; s++) begin
        pm_q[s] <= (s == 0) ? '0 : PM_W'(8);
        surv_q[s] <= '0;
      end
      cnt_q <= '0;
      decoded_valid <= 1'b0;
      decoded_bit <= 1'b0;
    end else if (in_valid) begin
      pm_q <= pm_d;
      surv_q <= surv_d;
      cnt_q <= cnt_d;
      decoded_valid <= valid_d;
      decoded_bit <= bit_d;
    end else begin
      decoded_valid <= 1'b0;
    end
  end
endmodule
